// File: rtl/phase_sequencer_pkg.sv
// Shared types and constants for the instruction phase sequencer.
// Holds the controller state enumeration, the six phase codes and the default counter width.
package phase_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [2:0] PH_0 = 3'b000;
    localparam logic [2:0] PH_1 = 3'b001;
    localparam logic [2:0] PH_2 = 3'b010;
    localparam logic [2:0] PH_3 = 3'b011;
    localparam logic [2:0] PH_4 = 3'b100;
    localparam logic [2:0] PH_5 = 3'b101;

    localparam int DEFAULT_COUNT_W = 16;

endpackage

// File: rtl/phase_sequencer_btn_sync.sv
// Push-button conditioner: a 2-flop synchronizer followed by a rising-edge detector.
// It produces a one-cycle pulse for each rising edge of the raw button input.
module btn_sync (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    // The pulse is high in the cycle after the synchronized level first rises.
    assign pulse = sync2_reg & ~prev_reg;

endmodule

// File: rtl/phase_sequencer.sv
// Six-phase instruction sequencer with run, single-step, stop and halt control.
// It also counts retired instructions.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int COUNT_W = DEFAULT_COUNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               step_mode,
    input  logic               hlt,
    output logic [2:0]         phase,
    output logic               running,
    output logic               halted,
    output logic               pc_we,
    output logic [COUNT_W-1:0] instr_count
);

    // Bit 0 carries start and bit 1 carries stop through identical conditioners.
    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;
    logic       start_p;
    logic       stop_p;

    assign btn_raw = {stop, start};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            btn_sync u_btn_sync (
                .clock (clock),
                .reset (reset),
                .btn   (btn_raw[gi]),
                .pulse (btn_pulse[gi])
            );
        end
    endgenerate

    assign start_p = btn_pulse[0];
    assign stop_p  = btn_pulse[1];

    state_t             state_reg,        state_next;
    logic [2:0]         phase_reg,        phase_next;
    logic [COUNT_W-1:0] count_reg,        count_next;
    logic               stop_pending_reg, stop_pending_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            phase_reg        <= PH_0;
            count_reg        <= '0;
            stop_pending_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            phase_reg        <= phase_next;
            count_reg        <= count_next;
            stop_pending_reg <= stop_pending_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        phase_next        = phase_reg;
        count_next        = count_reg;
        stop_pending_next = stop_pending_reg;
        unique case (state_reg)
            ST_IDLE: begin
                phase_next        = PH_0;
                stop_pending_next = 1'b0;
                // A simultaneous stop suppresses the start.
                if (start_p && !stop_p) begin
                    state_next = step_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_RUN, ST_STEP: begin
                if (phase_reg == PH_5) begin
                    phase_next        = PH_0;
                    stop_pending_next = 1'b0;
                    if (hlt) begin
                        state_next = ST_HALT;
                    end else begin
                        count_next = count_reg + COUNT_W'(1);
                        // A stop seen in this last phase still counts at this boundary.
                        if (state_reg == ST_STEP || stop_pending_reg || stop_p) begin
                            state_next = ST_IDLE;
                        end
                    end
                end else begin
                    phase_next = phase_reg + 3'd1;
                    if (state_reg == ST_RUN && stop_p) begin
                        stop_pending_next = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                phase_next = PH_0;
            end
            default: begin
                state_next = ST_IDLE;
                phase_next = PH_0;
            end
        endcase
    end

    assign phase       = phase_reg;
    assign running     = (state_reg == ST_RUN) || (state_reg == ST_STEP);
    assign halted      = (state_reg == ST_HALT);
    assign pc_we       = running && (phase_reg == PH_5) && !hlt;
    assign instr_count = count_reg;

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter: COUNT_W, 16, width of the retired-instruction counter.
REQ-002 clock  in  1  single system clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  run request from push-button; asynchronous to clock.
REQ-005 stop  in  1  stop request from push-button; asynchronous to clock.
REQ-006 step_mode  in  1  1 = each start executes one instruction; 0 = continuous run.
REQ-007 hlt  in  1  halt flag from the instruction decoder; valid in every phase of a HALT instruction.
REQ-008 phase  out  3  current execution phase fed to the decoder: 000,001,010,011,100,101.
REQ-009 running  out  1  high while state is RUN or STEP.
REQ-010 halted  out  1  high while state is HALT.
REQ-011 pc_we  out  1  PC write strobe for the instruction in progress.
REQ-012 instr_count  out  COUNT_W  number of retired instructions.

Function
REQ-013 States SHALL be IDLE, RUN, STEP and HALT.
REQ-014 start and stop SHALL each pass a 2-flop synchronizer plus a rising-edge detector; each edge yields a 1-cycle internal pulse (start_p, stop_p).
REQ-015 Latency: start rising before clock edge 1 SHALL make start_p high between edges 2 and 3, and change the state at edge 3.
REQ-016 IDLE: phase held at 000; start_p with step_mode=0 -> RUN; start_p with step_mode=1 -> STEP.
REQ-017 In RUN or STEP, phase SHALL be 000 in the first cycle after entry, then increment by one each cycle; 101 wraps to 000.
REQ-018 pc_we SHALL be combinational: running AND phase==101 AND hlt==0.
REQ-019 At phase 101 with hlt==1: next state HALT, phase 000, instr_count unchanged.
REQ-020 At phase 101 with hlt==0: instr_count increments by 1, modulo 2^COUNT_W; all-ones wraps to 0.
REQ-021 stop_p in RUN SHALL set a stop_pending flag; the current instruction completes, and at phase 101 the state goes to IDLE.
REQ-022 A stop_p arriving in phase 101 itself SHALL take effect at that same boundary.
REQ-023 STEP SHALL return to IDLE after phase 101 of its one instruction; stop_p in STEP has no further effect.
REQ-024 start_p in RUN, STEP or HALT SHALL be ignored; stop_p in IDLE or HALT SHALL be ignored.
REQ-025 start_p and stop_p together in IDLE: stop wins, state stays IDLE.
REQ-026 hlt and a pending stop together at phase 101: HALT wins.
REQ-027 HALT SHALL be left only by reset; phase stays 000.
REQ-028 hlt SHALL be ignored in phases 000-100 and in IDLE/HALT.

Reset
REQ-029 Reset SHALL immediately force:
- state IDLE, phase 000, running 0, halted 0, pc_we 0
- instr_count 0, stop_pending 0
- all synchronizer and edge flops 0
REQ-030 Reset asserted mid-instruction SHALL abandon the instruction; no pc_we pulse and no count increment occur for it.

Structure
REQ-031 A shared package SHALL hold:
- the state enumeration
- phase constants PH_0..PH_5 (3'b000..3'b101)
- default COUNT_W
REQ-032 One sub-module, btn_sync (2-flop synchronizer plus rising-edge pulse), SHALL be instantiated twice: for start and for stop.

Verification
REQ-033 step_mode=0, start pulse, hlt=0 -> RUN at edge 3; phase 000..101 repeats; pc_we high one cycle in six; instr_count 1 after first phase 101.
REQ-034 RUN, hlt=1 during second instruction -> at its phase 101: pc_we=0, state HALT, halted=1, instr_count=1; later start pulses ignored.
REQ-035 step_mode=1, three start pulses spaced 20 cycles -> three 6-phase sequences, each returning to IDLE; instr_count=3, running=0 between steps.
REQ-036 RUN, stop pulse detected at phase 010 -> phases 011,100,101 complete, pc_we pulses once, then IDLE with phase 000.
REQ-037 instr_count preset near wrap (COUNT_W=4, 15 retired) -> next retire gives 0; reset asserted at phase 011 -> all outputs 0 asynchronously.
REQ-038 hlt=1 and a pending stop at the same phase 101 -> HALT, not IDLE; simultaneous start/stop edges in IDLE -> remains IDLE.
